// File: rtl/submarine_pkg.sv
// Shared types and helpers for the submarine game engine: FSM state encoding,
// default-configuration widths and the board coordinate range check.
package submarine_pkg;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_PLAY,
        ST_EXEC,
        ST_RESP,
        ST_DONE
    } state_t;

    localparam int DEF_WIDTH    = 6;
    localparam int DEF_HEIGHT   = 6;
    localparam int DEF_NUM_SUBS = 4;
    localparam int ID_W         = $clog2(DEF_NUM_SUBS + 1);
    localparam int CNT_W        = $clog2(DEF_WIDTH * DEF_HEIGHT + 1);

    function automatic logic coord_ok(input int unsigned cx, input int unsigned cy,
                                      input int unsigned w, input int unsigned h);
        return (cx < w) && (cy < h);
    endfunction

endpackage

// File: rtl/submarine_board_mem.sv
// Board storage: one {sub id, shot bit} entry per cell, one shared write port,
// one combinational read port and a bulk clear of all shot bits for replay.
module submarine_board_mem #(
    parameter int DEPTH = 36,
    parameter int ID_W  = 3,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we_id,
    input  logic            we_shot,
    input  logic            clr_shot,
    input  logic [AW-1:0]   waddr,
    input  logic [ID_W-1:0] wid,
    input  logic [AW-1:0]   raddr,
    output logic [ID_W-1:0] rid,
    output logic            rshot
);

    logic [ID_W-1:0] id_mem [DEPTH];
    logic [DEPTH-1:0] shot_mem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) id_mem[i] <= '0;
            shot_mem <= '0;
        end else begin
            if (we_id) id_mem[waddr] <= wid;
            if (clr_shot)
                shot_mem <= '0;
            else if (we_shot)
                shot_mem[waddr] <= 1'b1;
        end
    end

    // Addresses past the last cell read back as unshot water.
    assign rid   = (int'(raddr) < DEPTH) ? id_mem[raddr] : '0;
    assign rshot = (int'(raddr) < DEPTH) ? shot_mem[raddr] : 1'b0;

endmodule

// File: rtl/submarine_game_engine.sv
// Submarine game core: runtime-loaded board, per-sub hit bookkeeping and a
// three-cycle shot handshake (accept, classify, respond) with replay support.
module submarine_game_engine #(
    parameter int WIDTH    = 6,
    parameter int HEIGHT   = 6,
    parameter int NUM_SUBS = 4,
    parameter int COORD_W  = 3,
    localparam int ID_W    = $clog2(NUM_SUBS + 1),
    localparam int CNT_W   = $clog2(WIDTH * HEIGHT + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_en,
    input  logic [COORD_W-1:0] load_x,
    input  logic [COORD_W-1:0] load_y,
    input  logic [ID_W-1:0]    load_id,
    input  logic               start,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic               cord_valid,
    output logic               busy,
    output logic               resp_valid,
    output logic               hit,
    output logic               sink,
    output logic [ID_W-1:0]    sink_id,
    output logic               repeat_shot,
    output logic               invalid,
    output logic               done,
    output logic [CNT_W-1:0]   shot_count
);
    import submarine_pkg::*;

    localparam int DEPTH = WIDTH * HEIGHT;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t             state;
    logic [COORD_W-1:0] cx_p0, cy_p0;
    logic [CNT_W-1:0]   sizes     [NUM_SUBS+1];
    logic [CNT_W-1:0]   remaining [NUM_SUBS+1];
    logic               res_hit_p1, res_sink_p1, res_rep_p1, res_inv_p1;
    logic [ID_W-1:0]    res_sid_p1;

    logic [AW-1:0]   mem_addr;
    logic [ID_W-1:0] cur_id;
    logic            cur_shot;
    logic            load_ok, load_wr, shot_ok, board_empty, all_sunk;

    function automatic logic [AW-1:0] cell_addr(input logic [COORD_W-1:0] cx,
                                                input logic [COORD_W-1:0] cy);
        return AW'(int'(cy) * WIDTH + int'(cx));
    endfunction

    assign mem_addr = (state == ST_LOAD) ? cell_addr(load_x, load_y) : cell_addr(cx_p0, cy_p0);
    assign load_ok  = coord_ok(32'(load_x), 32'(load_y), WIDTH, HEIGHT) && (int'(load_id) <= NUM_SUBS);
    assign load_wr  = (state == ST_LOAD) && load_en && !start && load_ok;
    assign shot_ok  = coord_ok(32'(cx_p0), 32'(cy_p0), WIDTH, HEIGHT);

    always_comb begin
        board_empty = 1'b1;
        all_sunk    = 1'b1;
        for (int i = 1; i <= NUM_SUBS; i++) begin
            if (sizes[i] != '0)     board_empty = 1'b0;
            if (remaining[i] != '0) all_sunk    = 1'b0;
        end
    end

    submarine_board_mem #(
        .DEPTH (DEPTH),
        .ID_W  (ID_W)
    ) u_board (
        .clk      (clk),
        .rst      (rst),
        .we_id    (load_wr),
        .we_shot  ((state == ST_EXEC) && shot_ok && !cur_shot),
        .clr_shot ((state == ST_DONE) && start),
        .waddr    (mem_addr),
        .wid      (load_id),
        .raddr    (mem_addr),
        .rid      (cur_id),
        .rshot    (cur_shot)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_LOAD;
            cx_p0       <= '0;
            cy_p0       <= '0;
            shot_count  <= '0;
            for (int i = 0; i <= NUM_SUBS; i++) begin
                sizes[i]     <= '0;
                remaining[i] <= '0;
            end
            res_hit_p1  <= 1'b0;
            res_sink_p1 <= 1'b0;
            res_rep_p1  <= 1'b0;
            res_inv_p1  <= 1'b0;
            res_sid_p1  <= '0;
            busy        <= 1'b0;
            resp_valid  <= 1'b0;
            hit         <= 1'b0;
            sink        <= 1'b0;
            sink_id     <= '0;
            repeat_shot <= 1'b0;
            invalid     <= 1'b0;
            done        <= 1'b0;
        end else begin
            resp_valid  <= 1'b0;
            hit         <= 1'b0;
            sink        <= 1'b0;
            sink_id     <= '0;
            repeat_shot <= 1'b0;
            invalid     <= 1'b0;
            case (state)
                ST_LOAD: begin
                    if (start) begin
                        if (board_empty) begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            remaining <= sizes;
                            state     <= ST_PLAY;
                        end
                    end else if (load_wr && (cur_id != load_id)) begin
                        // Rewriting a cell moves one unit of size from its old owner to the new one.
                        if (cur_id != '0)  sizes[cur_id]  <= sizes[cur_id] - CNT_W'(1);
                        if (load_id != '0) sizes[load_id] <= sizes[load_id] + CNT_W'(1);
                    end
                end
                // Stage p0: capture the request coordinates.
                ST_PLAY: begin
                    if (cord_valid) begin
                        cx_p0 <= x;
                        cy_p0 <= y;
                        busy  <= 1'b1;
                        state <= ST_EXEC;
                    end
                end
                // Stage p1: classify against the board and update bookkeeping.
                ST_EXEC: begin
                    res_hit_p1  <= 1'b0;
                    res_sink_p1 <= 1'b0;
                    res_rep_p1  <= 1'b0;
                    res_inv_p1  <= 1'b0;
                    res_sid_p1  <= '0;
                    if (!shot_ok) begin
                        res_inv_p1 <= 1'b1;
                    end else if (cur_shot) begin
                        res_rep_p1 <= 1'b1;
                    end else begin
                        if (shot_count != CNT_W'(DEPTH)) shot_count <= shot_count + CNT_W'(1);
                        if (cur_id != '0) begin
                            res_hit_p1 <= 1'b1;
                            if (remaining[cur_id] != '0)
                                remaining[cur_id] <= remaining[cur_id] - CNT_W'(1);
                            if (remaining[cur_id] == CNT_W'(1)) begin
                                res_sink_p1 <= 1'b1;
                                res_sid_p1  <= cur_id;
                            end
                        end
                    end
                    state <= ST_RESP;
                end
                // Stage p2: publish the result strobe.
                ST_RESP: begin
                    resp_valid  <= 1'b1;
                    hit         <= res_hit_p1;
                    sink        <= res_sink_p1;
                    sink_id     <= res_sid_p1;
                    repeat_shot <= res_rep_p1;
                    invalid     <= res_inv_p1;
                    busy        <= 1'b0;
                    if (all_sunk) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        state <= ST_PLAY;
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        remaining  <= sizes;
                        shot_count <= '0;
                        done       <= 1'b0;
                        state      <= ST_PLAY;
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_submarine_game_engine.sv
// Directed and randomised-board bench for submarine_game_engine on a 6x6 and an 8x5 board.
module tb_submarine_game_engine;

    logic clk;

    // 6x6 board, 4 subs
    logic       rst_a, load_en_a, start_a, cord_valid_a;
    logic [2:0] load_x_a, load_y_a, load_id_a, x_a, y_a;
    logic       busy_a, resp_valid_a, hit_a, sink_a, repeat_a, invalid_a, done_a;
    logic [2:0] sink_id_a;
    logic [5:0] shot_count_a;

    // 8x5 board, 3 subs
    logic       rst_b, load_en_b, start_b, cord_valid_b;
    logic [2:0] load_x_b, load_y_b, x_b, y_b;
    logic [1:0] load_id_b, sink_id_b;
    logic       busy_b, resp_valid_b, hit_b, sink_b, repeat_b, invalid_b, done_b;
    logic [5:0] shot_count_b;

    int errors = 0;
    int checks = 0;

    submarine_game_engine #(.WIDTH(6), .HEIGHT(6), .NUM_SUBS(4), .COORD_W(3)) dut_a (
        .clk(clk), .rst(rst_a), .load_en(load_en_a), .load_x(load_x_a), .load_y(load_y_a),
        .load_id(load_id_a), .start(start_a), .x(x_a), .y(y_a), .cord_valid(cord_valid_a),
        .busy(busy_a), .resp_valid(resp_valid_a), .hit(hit_a), .sink(sink_a),
        .sink_id(sink_id_a), .repeat_shot(repeat_a), .invalid(invalid_a), .done(done_a),
        .shot_count(shot_count_a)
    );

    submarine_game_engine #(.WIDTH(8), .HEIGHT(5), .NUM_SUBS(3), .COORD_W(3)) dut_b (
        .clk(clk), .rst(rst_b), .load_en(load_en_b), .load_x(load_x_b), .load_y(load_y_b),
        .load_id(load_id_b), .start(start_b), .x(x_b), .y(y_b), .cord_valid(cord_valid_b),
        .busy(busy_b), .resp_valid(resp_valid_b), .hit(hit_b), .sink(sink_b),
        .sink_id(sink_id_b), .repeat_shot(repeat_b), .invalid(invalid_b), .done(done_b),
        .shot_count(shot_count_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x, y, hit, sink, sid, rep, inv, done, cnt;
    } vec_t;

    vec_t va [8];
    vec_t vr [3];

    function automatic int pk(input int h, input int s, input int sid, input int r, input int i, input int d);
        return int'({24'b0, h[0], s[0], sid[2:0], r[0], i[0], d[0]});
    endfunction

    function automatic int act_a();
        return pk(int'(hit_a), int'(sink_a), int'(sink_id_a), int'(repeat_a), int'(invalid_a), int'(done_a));
    endfunction

    function automatic int act_b();
        return pk(int'(hit_b), int'(sink_b), int'(sink_id_b), int'(repeat_b), int'(invalid_b), int'(done_b));
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic load_a(input int lx, input int ly, input int id);
        load_x_a = 3'(lx); load_y_a = 3'(ly); load_id_a = 3'(id); load_en_a = 1'b1;
        @(negedge clk);
        load_en_a = 1'b0;
    endtask

    task automatic load_b(input int lx, input int ly, input int id);
        load_x_b = 3'(lx); load_y_b = 3'(ly); load_id_b = 2'(id); load_en_b = 1'b1;
        @(negedge clk);
        load_en_b = 1'b0;
    endtask

    task automatic shot_a(input int sx, input int sy, output int got, output int lat);
        x_a = 3'(sx); y_a = 3'(sy); cord_valid_a = 1'b1;
        @(negedge clk);
        cord_valid_a = 1'b0;
        got = 0; lat = 0;
        for (int i = 0; i < 6; i++) begin
            if (resp_valid_a) begin got = 1; break; end
            @(negedge clk); lat++;
        end
    endtask

    task automatic shot_b(input int sx, input int sy, output int got);
        x_b = 3'(sx); y_b = 3'(sy); cord_valid_b = 1'b1;
        @(negedge clk);
        cord_valid_b = 1'b0;
        got = 0;
        for (int i = 0; i < 6; i++) begin
            if (resp_valid_b) begin got = 1; break; end
            @(negedge clk);
        end
    endtask

    initial begin
        int got, lat, rv, bz, gap, bcnt;
        int ids [40];
        int order [40];
        int rem [4];
        int stop, done_seen, exp_h, exp_s, exp_sid, exp_d, c, tmp, j;

        clk = 0;
        rst_a = 1; load_en_a = 0; start_a = 0; cord_valid_a = 0;
        load_x_a = 0; load_y_a = 0; load_id_a = 0; x_a = 0; y_a = 0;
        rst_b = 1; load_en_b = 0; start_b = 0; cord_valid_b = 0;
        load_x_b = 0; load_y_b = 0; load_id_b = 0; x_b = 0; y_b = 0;

        //                x  y  hit snk sid rep inv done cnt
        va[0] = '{0, 0, 1, 0, 0, 0, 0, 0, 1};
        va[1] = '{0, 0, 0, 0, 0, 1, 0, 0, 1};
        va[2] = '{6, 2, 0, 0, 0, 0, 1, 0, 1};
        va[3] = '{2, 2, 0, 0, 0, 0, 0, 0, 2};
        va[4] = '{5, 5, 0, 0, 0, 0, 0, 0, 3};
        va[5] = '{1, 1, 0, 0, 0, 0, 0, 0, 4};
        va[6] = '{0, 1, 1, 1, 1, 0, 0, 0, 5};
        va[7] = '{3, 3, 1, 1, 2, 0, 0, 1, 6};
        vr[0] = '{0, 0, 1, 0, 0, 0, 0, 0, 1};
        vr[1] = '{0, 1, 1, 1, 1, 0, 0, 0, 2};
        vr[2] = '{3, 3, 1, 1, 2, 0, 0, 1, 3};

        repeat (2) @(negedge clk);
        rst_a = 0; rst_b = 0;
        check("reset_flags", act_a(), 0);
        check("reset_busy_resp_cnt", int'({busy_a, resp_valid_a, shot_count_a}), 0);

        // Board: sub1 at (0,0),(0,1); sub2 at (3,3); (5,5) set then cleared;
        // (7,0) is out of range and would alias onto cell (1,1) if accepted.
        load_a(0, 0, 1);
        load_a(0, 1, 1);
        load_a(3, 3, 2);
        load_a(5, 5, 1);
        load_a(5, 5, 0);
        load_a(7, 0, 3);
        start_a = 1; @(negedge clk); start_a = 0;
        check("play_idle_busy_done", int'({busy_a, done_a}), 0);

        for (int i = 0; i < 8; i++) begin
            shot_a(va[i].x, va[i].y, got, lat);
            check("resp_seen", got, 1);
            if (got == 1) begin
                check("latency", lat, 2);
                check("resp_flags", act_a(), pk(va[i].hit, va[i].sink, va[i].sid, va[i].rep, va[i].inv, va[i].done));
                check("shot_count", int'(shot_count_a), va[i].cnt);
            end
        end

        // DONE ignores requests and holds done
        x_a = 2; y_a = 2; cord_valid_a = 1;
        rv = 0; bz = 0;
        repeat (5) begin
            @(negedge clk);
            rv += int'(resp_valid_a); bz += int'(busy_a);
        end
        check("done_no_resp", rv, 0);
        check("done_no_busy", bz, 0);
        check("done_held", int'(done_a), 1);

        // Replay with cord_valid held high the whole time
        start_a = 1; @(negedge clk); start_a = 0;
        check("replay_done_clr", int'(done_a), 0);
        check("replay_cnt_clr", int'(shot_count_a), 0);
        x_a = 3'(vr[0].x); y_a = 3'(vr[0].y);
        for (int k = 0; k < 3; k++) begin
            gap = 0; bcnt = 0; got = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                gap++;
                bcnt += int'(busy_a);
                if (resp_valid_a) begin got = 1; break; end
            end
            check("stream_resp_seen", got, 1);
            check("stream_gap", gap, 3);
            check("stream_busy_cycles", bcnt, 2);
            check("stream_flags", act_a(), pk(vr[k].hit, vr[k].sink, vr[k].sid, vr[k].rep, vr[k].inv, vr[k].done));
            check("stream_cnt", int'(shot_count_a), vr[k].cnt);
            if (k < 2) begin x_a = 3'(vr[k+1].x); y_a = 3'(vr[k+1].y); end
        end
        rv = 0;
        repeat (4) begin @(negedge clk); rv += int'(resp_valid_a); end
        check("stream_no_resp_after_done", rv, 0);
        cord_valid_a = 0;

        // Reset while a shot is being classified
        start_a = 1; @(negedge clk); start_a = 0;
        x_a = 0; y_a = 0; cord_valid_a = 1;
        @(posedge clk);
        #1;
        rst_a = 1; cord_valid_a = 0;
        @(negedge clk);
        check("rst_exec_outputs", int'({busy_a, resp_valid_a, hit_a, sink_a, sink_id_a, repeat_a, invalid_a, done_a, shot_count_a}), 0);
        rst_a = 0;
        start_a = 1; @(negedge clk); start_a = 0;
        check("empty_start_done", int'(done_a), 1);
        check("empty_start_busy", int'(busy_a), 0);

        // Ten random boards on 8x5, every cell shot once in random order
        for (int g = 0; g < 10; g++) begin
            rst_b = 1; @(negedge clk); rst_b = 0;
            for (int s = 0; s < 4; s++) rem[s] = 0;
            for (int cc = 0; cc < 40; cc++) begin
                ids[cc] = int'($urandom_range(0, 3));
                if (cc == 0 && ids[cc] == 0) ids[cc] = 1 + (g % 3);
                if (ids[cc] != 0) rem[ids[cc]]++;
                load_b(cc % 8, cc / 8, ids[cc]);
                order[cc] = cc;
            end
            for (int i = 39; i > 0; i--) begin
                j = int'($urandom_range(0, i));
                tmp = order[i]; order[i] = order[j]; order[j] = tmp;
            end
            start_b = 1; @(negedge clk); start_b = 0;
            stop = 0; done_seen = 0;
            for (int k = 0; k < 40 && stop == 0; k++) begin
                c = order[k];
                shot_b(c % 8, c / 8, got);
                if (done_seen == 1) begin
                    check("rand_no_resp_after_done", got, 0);
                    stop = 1;
                end else begin
                    check("rand_resp_seen", got, 1);
                    exp_h = (ids[c] != 0) ? 1 : 0;
                    exp_s = 0; exp_sid = 0;
                    if (exp_h == 1) begin
                        rem[ids[c]]--;
                        if (rem[ids[c]] == 0) begin exp_s = 1; exp_sid = ids[c]; end
                    end
                    exp_d = (rem[1] == 0 && rem[2] == 0 && rem[3] == 0) ? 1 : 0;
                    if (got == 1) begin
                        check("rand_flags", act_b(), pk(exp_h, exp_s, exp_sid, 0, 0, exp_d));
                        check("rand_cnt", int'(shot_count_b), k + 1);
                    end
                    if (exp_d == 1) done_seen = 1;
                end
            end
            check("rand_done_by_40", int'(done_b), 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
